// File: rtl/mult_dot_accumulator.sv
// Sums every VEC_LEN consecutive products from the multiplier into one dot-product result and
// buffers completed sums in a small FIFO that drains on a valid/ready handshake.
module mult_dot_accumulator #(
    parameter int DATAWIDTH = 4,
    parameter int VEC_LEN   = 4,
    parameter int ACC_WIDTH = 2*DATAWIDTH + $clog2(VEC_LEN),
    parameter int OUT_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [2*DATAWIDTH-1:0] i_product,
    input  logic                   i_clear,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [ACC_WIDTH-1:0]   o_sum,
    output logic                   o_busy,
    output logic                   o_drop
);
    localparam int PW    = 2*DATAWIDTH;
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(OUT_DEPTH);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 drop_q, drop_d;
    logic [ACC_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    logic [ACC_WIDTH-1:0] prod_ext, acc_base, sum_new;
    logic [CNT_W-1:0]     cnt_eff;
    logic                 last, full, pop, do_push;

    // Output handshake: o_valid means the FIFO head in o_sum is a completed sum; it is consumed
    // on a rising edge where o_valid && o_ready, and o_valid/o_sum hold while o_ready is low.
    assign o_valid = (occ_q != '0);
    assign o_sum   = mem_q[rd_ptr_q];
    assign o_busy  = (cnt_q != '0);
    assign o_drop  = drop_q;

    always_comb begin
        prod_ext           = '0;
        prod_ext[PW-1:0]   = i_product;
        // A same-cycle clear discards old data, so the incoming product sees an empty vector.
        cnt_eff  = i_clear ? '0 : cnt_q;
        acc_base = (cnt_eff == '0) ? '0 : acc_q;
        sum_new  = acc_base + prod_ext;
        last     = i_valid && (cnt_eff == LAST_CNT);
        pop      = o_valid && o_ready;
        full     = (occ_q == FULL_OCC);
        do_push  = last && (!full || pop);

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (i_clear) begin
            acc_d  = '0;
            cnt_d  = '0;
            drop_d = 1'b0;
        end
        if (i_valid) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_new;
                cnt_d = cnt_eff + CNT_W'(1);
            end
        end
        if (last && !do_push) begin
            drop_d = 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= sum_new;
            end
        end
    end
endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Scoreboard bench for mult_dot_accumulator: a cycle model predicts FIFO contents, busy and drop;
// a second instance with VEC_LEN=1 must echo every product.
module tb_mult_dot_accumulator;
    localparam int VL    = 4;
    localparam int AW    = 10;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst, i_valid, i_clear, ready;
    logic [7:0] i_product;
    logic       o_valid, o_busy, o_drop;
    logic [AW-1:0] o_sum;
    logic       o_valid1, o_busy1, o_drop1;
    logic [7:0] o_sum1;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_q[$];
    logic [7:0]    exp1_q[$];
    int            m_cnt;
    logic [AW-1:0] m_acc;
    logic          m_drop;

    always #5 clk = ~clk;

    mult_dot_accumulator #(.DATAWIDTH(4), .VEC_LEN(VL), .ACC_WIDTH(AW), .OUT_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_clear(i_clear),
        .o_valid(o_valid), .o_ready(ready), .o_sum(o_sum), .o_busy(o_busy), .o_drop(o_drop)
    );

    mult_dot_accumulator #(.DATAWIDTH(4), .VEC_LEN(1), .ACC_WIDTH(8), .OUT_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_clear(i_clear),
        .o_valid(o_valid1), .o_ready(1'b1), .o_sum(o_sum1), .o_busy(o_busy1), .o_drop(o_drop1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("o_sum", 32'(o_sum), 32'(exp_q[0]));
        check("o_busy", 32'(o_busy), 32'(m_cnt != 0));
        check("o_drop", 32'(o_drop), 32'(m_drop));
        check("v1_valid", 32'(o_valid1), 32'(exp1_q.size() != 0));
        if (exp1_q.size() != 0) check("v1_sum", 32'(o_sum1), 32'(exp1_q[0]));
        check("v1_busy", 32'(o_busy1), 32'd0);
        check("v1_drop", 32'(o_drop1), 32'd0);
    endtask

    // Predicts the effect of the coming rising edge from the inputs just applied.
    task automatic model_edge(input logic v, input logic [7:0] p, input logic c, input logic r);
        logic [AW-1:0] done;
        if (r && exp_q.size() != 0) void'(exp_q.pop_front());
        if (c) begin
            m_cnt  = 0;
            m_acc  = '0;
            m_drop = 1'b0;
        end
        if (v) begin
            m_acc = (m_cnt == 0) ? AW'(p) : m_acc + AW'(p);
            m_cnt++;
            if (m_cnt == VL) begin
                done  = m_acc;
                m_cnt = 0;
                m_acc = '0;
                if (exp_q.size() < DEPTH) exp_q.push_back(done);
                else m_drop = 1'b1;
            end
        end
        if (exp1_q.size() != 0) void'(exp1_q.pop_front());
        if (v) exp1_q.push_back(p);
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic c, input logic r);
        @(negedge clk);
        compare_outputs();
        i_valid   = v;
        i_product = p;
        i_clear   = c;
        ready     = r;
        model_edge(v, p, c, r);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_product = '0;
        i_clear   = 1'b0;
        ready     = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum", 32'(o_sum), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_drop", 32'(o_drop), 32'd0);
        check("rst_v1_valid", 32'(o_valid1), 32'd0);
        exp_q.delete();
        exp1_q.delete();
        m_cnt  = 0;
        m_acc  = '0;
        m_drop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        apply_reset();

        // 225 x4 -> 900 one cycle after the last product
        for (int i = 0; i < 4; i++) step(1'b1, 8'd225, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_sum", 32'(o_sum), 32'd900);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // back-to-back vectors 1..4 and 5..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 5) check("t2_sum_a", 32'(o_sum), 32'd10);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t2_sum_b", 32'(o_sum), 32'd26);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // three vectors into a blocked FIFO: third sum dropped
        for (int i = 0; i < 12; i++) step(1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("t3_drop", 32'(o_drop), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t3_empty", 32'(o_valid), 32'd0);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t3_drop_clr", 32'(o_drop), 32'd0);

        // FIFO full, pop coincides with the third completion: no drop
        for (int i = 0; i < 11; i++) step(1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd1, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t4_no_drop", 32'(o_drop), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

        // clear with a same-cycle product restarts the vector
        step(1'b1, 8'd9, 1'b0, 1'b1);
        step(1'b1, 8'd9, 1'b0, 1'b1);
        step(1'b1, 8'd3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd3, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t5_sum", 32'(o_sum), 32'd12);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // reset mid-vector with one sum buffered
        for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b0, 1'b0);
        step(1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd1, 1'b0, 1'b0);
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("t6_sum", 32'(o_sum), 32'd8);

        // random traffic with backpressure and occasional clears
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
